// File: rtl/pwm_pkg.sv
// Shared constants and enumerations for the multi-channel PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_CBITS = 15;
  localparam int unsigned PWM_NCH   = 4;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_timebase.sv
// Shared period counter: owns cnt, direction, active period/mode and the
// period-boundary strobe used by every channel.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned      CBITS      = PWM_CBITS,
  parameter logic [CBITS-1:0] DEF_PERIOD = 15'h7FFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             center,
  input  logic [CBITS-1:0] period,
  output logic [CBITS-1:0] cnt_o,
  output logic             boundary_o
);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] per_q, per_d;
  cnt_dir_e         dir_q, dir_d;
  pwm_mode_e        mode_q, mode_d;

  logic             boundary_s;
  logic [CBITS-1:0] per_eff_s;
  pwm_mode_e        mode_eff_s;
  logic [CBITS-1:0] cnt_inc_s;

  // Boundary detection; at a boundary the newly sampled period/mode already
  // steer the counter so the new period starts with its exact length.
  always_comb begin
    boundary_s = en && (cnt_q == {CBITS{1'b0}}) &&
                 ((mode_q == PWM_EDGE) || (dir_q == DIR_UP));
    if (boundary_s) begin
      per_eff_s  = period;
      mode_eff_s = center ? PWM_CENTER : PWM_EDGE;
    end else begin
      per_eff_s  = per_q;
      mode_eff_s = mode_q;
    end
    cnt_inc_s = cnt_q + CBITS'(1);
  end

  // Counter next-state: edge sawtooth or center triangle, held at 0 when idle.
  always_comb begin
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    per_d  = per_eff_s;
    mode_d = mode_eff_s;
    if (!en) begin
      cnt_d = {CBITS{1'b0}};
      dir_d = DIR_UP;
    end else if (mode_eff_s == PWM_EDGE) begin
      dir_d = DIR_UP;
      // >= rather than == keeps the count bounded whatever the period history
      cnt_d = (cnt_q >= per_eff_s) ? {CBITS{1'b0}} : cnt_inc_s;
    end else if (per_eff_s == {CBITS{1'b0}}) begin
      cnt_d = {CBITS{1'b0}};
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      cnt_d = cnt_inc_s;
      dir_d = (cnt_inc_s >= per_eff_s) ? DIR_DOWN : DIR_UP;
    end else if (cnt_q <= CBITS'(1)) begin
      cnt_d = {CBITS{1'b0}};
      dir_d = DIR_UP;
    end else begin
      cnt_d = cnt_q - CBITS'(1);
      dir_d = DIR_DOWN;
    end
  end

  // Timebase state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CBITS{1'b0}};
      dir_q  <= DIR_UP;
      per_q  <= DEF_PERIOD;
      mode_q <= PWM_EDGE;
    end else begin
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      per_q  <= per_d;
      mode_q <= mode_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign boundary_o = boundary_s;

endmodule

// File: rtl/pwm_multi_ch.sv
// NCH-channel PWM generator sharing one timebase; duty writes land in a
// shadow register and are committed to the comparator only at a period boundary.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned      CBITS      = PWM_CBITS,
  parameter int unsigned      NCH        = PWM_NCH,
  parameter int unsigned      CHW        = 2,
  parameter logic [CBITS-1:0] DEF_PERIOD = 15'h7FFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             center,
  input  logic [CBITS-1:0] period,
  input  logic [NCH-1:0]   inv,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [CBITS-1:0] wr_duty,
  output logic [NCH-1:0]   pulse_out,
  output logic             period_start
);

  logic [CBITS-1:0] cnt_s;
  logic             boundary_s;
  logic             wr_fire_s;
  logic [NCH-1:0]   pulse_d, pulse_q;
  logic             pstart_q;

  pwm_timebase #(
    .CBITS      (CBITS),
    .DEF_PERIOD (DEF_PERIOD)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .center     (center),
    .period     (period),
    .cnt_o      (cnt_s),
    .boundary_o (boundary_s)
  );

  // Writes are refused only in the commit cycle, so a write can never race it.
  assign wr_ready  = ~boundary_s;
  assign wr_fire_s = wr_valid & ~boundary_s;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CBITS-1:0] shadow_q, shadow_d;
    logic [CBITS-1:0] act_q, act_d;
    logic             pend_q, pend_d;
    logic             sel_s;
    logic             raw_s;

    assign sel_s = wr_fire_s && (wr_ch == CHW'(i));

    // Shadow capture and boundary commit; the two never coincide.
    always_comb begin
      shadow_d = shadow_q;
      act_d    = act_q;
      pend_d   = pend_q;
      if (boundary_s && pend_q) begin
        act_d  = shadow_q;
        pend_d = 1'b0;
      end else if (sel_s) begin
        shadow_d = wr_duty;
        pend_d   = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end

    // Per-channel duty registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q <= {CBITS{1'b0}};
        act_q    <= {CBITS{1'b0}};
        pend_q   <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        act_q    <= act_d;
        pend_q   <= pend_d;
      end
    end

    assign raw_s      = (cnt_s < act_q);
    assign pulse_d[i] = en ? (raw_s ^ inv[i]) : inv[i];
  end

  // Output registers; reset forces 0 irrespective of polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q  <= {NCH{1'b0}};
      pstart_q <= 1'b0;
    end else begin
      pulse_q  <= pulse_d;
      pstart_q <= boundary_s;
    end
  end

  assign pulse_out    = pulse_q;
  assign period_start = pstart_q;

endmodule
